md_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer beside the single-cycle execute ALU.
- Accepts one MUL/MULH/DIV/REM operation per handshake and iterates a shared 64-bit shift datapath for 32 cycles, then returns one registered 32-bit result.
- The execute stage stalls on ready_o/busy_o; the hazard unit cancels in-flight work with flush_i.

---
 rtl/md_pkg.sv | 19 +
 rtl/md_seq_if.sv | 18 +
 rtl/md_step.sv | 29 ++
 rtl/md_seq.sv | 110 +++++++++++
 tb/tb_md_seq.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package md_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_MULH = 2'b01,
    MD_DIV  = 2'b10,
    MD_REM  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } md_state_t;
endpackage

// File: rtl/md_seq_if.sv
// Request/response bundle between the execute stage and the md sequencer.
interface md_seq_if;
  import md_pkg::*;
  logic            valid_i;
  logic            ready_o;
  md_op_t          op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (output valid_i, op_i, a_i, b_i, flush_i,
                  input  ready_o, busy_o, done_o, result_o);
  modport slave  (input  valid_i, op_i, a_i, b_i, flush_i,
                  output ready_o, busy_o, done_o, result_o);
endinterface

// File: rtl/md_step.sv
// One iteration of the shared 64-bit datapath: shift-add for multiply,
// shift-compare-subtract (restoring) for divide.
module md_step
  import md_pkg::*;
(
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_mag,
  input  logic              i_is_div,
  output logic [2*XLEN-1:0] o_acc
);
  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shl;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  always_comb begin
    // multiply: {hi,lo}, lo holds the remaining multiplier bits
    w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_mag} : '0);
    // divide: {rem,quot}, quotient bits shift in from the right
    w_shl  = i_acc[2*XLEN-1:XLEN-1];
    w_ge   = (w_shl >= {1'b0, i_mag});
    w_diff = w_shl - {1'b0, i_mag};
    if (i_is_div)
      o_acc = w_ge ? {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1}
                   : {w_shl[XLEN-1:0],  i_acc[XLEN-2:0], 1'b0};
    else
      o_acc = {w_sum, i_acc[XLEN-1:1]};
  end
endmodule

// File: rtl/md_seq.sv
// Multi-cycle MUL/MULH/DIV/REM sequencer: magnitudes iterate through md_step
// for XLEN cycles, then one FIN cycle applies signs and special cases.
module md_seq
  import md_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  md_seq_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN - 1);

  md_state_t         r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  md_op_t            r_op;
  logic              r_sa, r_sb, r_dz, r_ovf;
  logic [XLEN-1:0]   r_mag;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  logic              w_accept;
  logic              w_ready;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic [2*XLEN-1:0] w_acc_nx;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_fixed;

  // the done cycle is not acceptable, so back-to-back ops never overlap a pulse
  assign w_ready  = (r_state == IDLE) && !r_done;
  assign w_accept = bus.valid_i && w_ready && !bus.flush_i;
  assign w_abs_a  = bus.a_i[XLEN-1] ? -bus.a_i : bus.a_i;
  assign w_abs_b  = bus.b_i[XLEN-1] ? -bus.b_i : bus.b_i;

  md_step u_step (
    .i_acc   (r_acc),
    .i_mag   (r_mag),
    .i_is_div(r_op[1]),
    .o_acc   (w_acc_nx)
  );

  always_comb begin
    w_state_nx = r_state;
    if (bus.flush_i) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nx = RUN;
        RUN:     if (r_cnt == CNT_MAX) w_state_nx = FIN;
        FIN:     w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    w_prod  = (r_sa ^ r_sb) ? -r_acc : r_acc;
    w_quot  = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    // with a zero divisor the remainder is |a|, so sign-fixing restores a
    w_rem   = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_fixed = '0;
    case (r_op)
      MD_MUL:  w_fixed = w_prod[XLEN-1:0];
      MD_MULH: w_fixed = w_prod[2*XLEN-1:XLEN];
      MD_DIV:  w_fixed = r_dz ? '1 : (r_ovf ? INT_MIN : w_quot);
      MD_REM:  w_fixed = r_ovf ? '0 : w_rem;
      default: w_fixed = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= MD_MUL;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_mag    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_op  <= bus.op_i;
        r_sa  <= bus.a_i[XLEN-1];
        r_sb  <= bus.b_i[XLEN-1];
        r_dz  <= (bus.b_i == '0);
        r_ovf <= (bus.a_i == INT_MIN) && (bus.b_i == '1);
        r_cnt <= '0;
        r_mag <= bus.op_i[1] ? w_abs_b : w_abs_a;
        r_acc <= {{XLEN{1'b0}}, (bus.op_i[1] ? w_abs_a : w_abs_b)};
      end else if (r_state == RUN && !bus.flush_i) begin
        r_acc <= w_acc_nx;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == FIN && !bus.flush_i) begin
        r_result <= w_fixed;
        r_done   <= 1'b1;
      end
    end
  end

  assign bus.ready_o  = w_ready;
  assign bus.busy_o   = (r_state != IDLE);
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_md_seq.sv
// Scoreboard bench for md_seq: driver pushes model results at accept,
// monitor pops and checks value and latency on every done pulse.
module tb_md_seq;
  import md_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  logic [31:0] last_res = '0;
  logic prev_done = 1'b0;

  typedef struct { logic [31:0] res; int cyc; } exp_t;
  exp_t exp_q[$];

  md_seq_if bus();

  md_seq dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_md(md_op_t op, logic [31:0] a, logic [31:0] b);
    longint p;
    int sa, sb;
    sa = a;
    sb = b;
    p = longint'(sa) * longint'(sb);
    case (op)
      MD_MUL:  return p[31:0];
      MD_MULH: return p[63:32];
      MD_DIV:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == INT_MIN && sb == -1) return INT_MIN;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (a == INT_MIN && sb == -1) return 32'h0;
        return sa % sb;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return INT_MIN;
      4: return 32'(int'($urandom_range(0, 200)) - 100);
      default: return $urandom;
    endcase
  endfunction

  // monitor: compares on done_o, plus output invariants every cycle
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.busy_o && bus.ready_o) chk("busy_ready_excl", 32'h1, 32'h0);
      if (bus.done_o && prev_done)   chk("done_twice", 32'h1, 32'h0);
      if (bus.done_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", bus.result_o, e.res);
          chk("latency", 32'(cyc - e.cyc), 32'd33);
          last_res = e.res;
        end
      end else if (bus.result_o !== last_res) begin
        chk("result_hold", bus.result_o, last_res);
      end
    end
    prev_done = bus.done_o;
  end

  // abort_at >= 0: abort after that many RUN edges, by flush or by reset
  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input int abort_at, input bit by_rst);
    int n;
    n = 0;
    while (!bus.ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("ready_timeout", 32'h0, 32'h1);
      return;
    end
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.a_i     = $urandom;
    bus.b_i     = $urandom;
    chk("accept_busy", {31'h0, bus.busy_o}, 32'h1);
    chk("accept_ready", {31'h0, bus.ready_o}, 32'h0);
    if (abort_at < 0) begin
      exp_q.push_back('{ref_md(op, a, b), cyc});
      return;
    end
    repeat (abort_at) @(posedge clk);
    #1;
    if (by_rst) rst = 1'b1; else bus.flush_i = 1'b1;
    @(posedge clk); #1;
    if (by_rst) begin
      rst = 1'b0;
      last_res = '0;
      chk("rst_result", bus.result_o, 32'h0);
    end else begin
      bus.flush_i = 1'b0;
      chk("flush_result", bus.result_o, last_res);
    end
    chk("abort_busy", {31'h0, bus.busy_o}, 32'h0);
    chk("abort_ready", {31'h0, bus.ready_o}, 32'h1);
    chk("abort_done", {31'h0, bus.done_o}, 32'h0);
    repeat (36) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = MD_MUL;
    bus.a_i     = '0;
    bus.b_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", bus.result_o, 32'h0);
    chk("rst_done", {31'h0, bus.done_o}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy_o}, 32'h0);
    chk("rst_ready", {31'h0, bus.ready_o}, 32'h1);
    rst = 1'b0;
    mon_en = 1'b1;

    issue(MD_MUL,  32'd7,       32'hFFFF_FFFD, -1, 0);
    issue(MD_MULH, INT_MIN,     INT_MIN,       -1, 0);
    issue(MD_MULH, 32'hFFFF_FFFF, 32'd1,       -1, 0);
    issue(MD_DIV,  32'hFFFF_FFF9, 32'd2,       -1, 0);
    issue(MD_REM,  32'hFFFF_FFF9, 32'd2,       -1, 0);
    issue(MD_DIV,  32'd5,       32'd0,         -1, 0);
    issue(MD_REM,  32'd5,       32'd0,         -1, 0);
    issue(MD_DIV,  INT_MIN,     32'hFFFF_FFFF, -1, 0);
    issue(MD_REM,  INT_MIN,     32'hFFFF_FFFF, -1, 0);
    issue(MD_MUL,  32'd123,     32'd456,       10, 0);
    issue(MD_DIV,  32'd100,     32'd7,         -1, 0);
    issue(MD_MUL,  32'd9,       32'd9,         32, 0);
    issue(MD_REM,  32'd1000,    32'd7,         -1, 0);
    issue(MD_DIV,  32'd77,      32'd5,          5, 1);

    // valid together with flush must not be accepted
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i    = MD_DIV;
    bus.a_i     = 32'd50;
    bus.b_i     = 32'd3;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    chk("vflush_busy", {31'h0, bus.busy_o}, 32'h0);
    chk("vflush_ready", {31'h0, bus.ready_o}, 32'h1);
    repeat (36) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++)
      issue(md_op_t'($urandom_range(0, 3)), pick(), pick(), -1, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
